// File: rtl/servo_pwm_capture.sv
// Servo PWM receiver: measures the high time of an asynchronous pulse train and
// decodes the generator's position encoding, flagging malformed pulses and signal loss.
module servo_pwm_capture #(
   parameter int OFFSET    = 165,
   parameter int MIN_WIDTH = 42240,
   parameter int MAX_WIDTH = 107775,
   parameter int TIMEOUT   = 1500000,
   parameter int CNT_W     = 21
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       pwm_in,
   output logic [7:0] position,
   output logic       pos_valid,
   output logic       pulse_err,
   output logic       signal_lost
);

   typedef enum logic [1:0] {
      ARM,
      WAIT_RISE,
      HIGH
   } state_t;

   localparam logic [CNT_W-1:0] MIN_C     = CNT_W'(MIN_WIDTH);
   localparam logic [CNT_W-1:0] MAX_C     = CNT_W'(MAX_WIDTH);
   localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0] OFFSET_C  = CNT_W'(OFFSET);
   localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);

   state_t           state;
   logic             s1, s2, s3;
   logic [1:0]       fill;
   logic [CNT_W-1:0] width_cnt;
   logic [CNT_W-1:0] period_cnt;
   logic [CNT_W-1:0] period_next;
   logic [7:0]       pos_calc;
   logic             rise, fall, primed, in_range;

   // The reset value of s2 is not a real sample of the pin, so ARM only trusts
   // s2 once two clocks have pushed genuine samples through the synchronizer.
   // NOTE: every flop uses non-blocking assignment so all state updates see the
   // values from before the edge, independent of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1   <= 1'b0;
         s2   <= 1'b0;
         s3   <= 1'b0;
         fill <= 2'b00;
      end else begin
         s1   <= pwm_in;
         s2   <= s1;
         s3   <= s2;
         fill <= {fill[0], 1'b1};
      end
   end

   assign rise     = s2 & ~s3;
   assign fall     = ~s2 & s3;
   assign primed   = fill[1];
   assign in_range = (width_cnt >= MIN_C) && (width_cnt <= MAX_C);
   assign pos_calc = 8'((width_cnt >> 8) - OFFSET_C);

   // NOTE: assign a default before any branch so the combinational block can
   // never hold a value and infer a latch.
   always_comb begin
      period_next = period_cnt;
      if (rise) begin
         period_next = '0;
      end else if (period_cnt != TIMEOUT_C) begin
         period_next = period_cnt + ONE_C;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= ARM;
         width_cnt   <= '0;
         period_cnt  <= '0;
         position    <= 8'd0;
         pos_valid   <= 1'b0;
         pulse_err   <= 1'b0;
         signal_lost <= 1'b1;
      end else begin
         pos_valid  <= 1'b0;
         pulse_err  <= 1'b0;
         period_cnt <= period_next;

         // An accepted pulse later in this block overrides a same-cycle expiry.
         if (period_next == TIMEOUT_C) begin
            signal_lost <= 1'b1;
         end

         case (state)
            ARM: begin
               if (primed && !s2) begin
                  state <= WAIT_RISE;
               end
            end

            WAIT_RISE: begin
               if (rise) begin
                  width_cnt <= ONE_C;
                  state     <= HIGH;
               end
            end

            HIGH: begin
               if (s2) begin
                  if (width_cnt >= MAX_C) begin
                     width_cnt <= MAX_C + ONE_C;
                     pulse_err <= 1'b1;
                     state     <= ARM;
                  end else begin
                     width_cnt <= width_cnt + ONE_C;
                  end
               end else if (fall) begin
                  if (in_range) begin
                     position    <= pos_calc;
                     pos_valid   <= 1'b1;
                     signal_lost <= 1'b0;
                  end else begin
                     pulse_err <= 1'b1;
                  end
                  state <= WAIT_RISE;
               end
            end

            default: state <= ARM;
         endcase
      end
   end

endmodule

// File: doc/servo_pwm_capture.md
Name: servo_pwm_capture

Overview:
- Receive-side counterpart of the board's servo PWM generator.
- Samples an external servo pulse train (1 ms-2 ms class pulses at 50 MHz) and measures the high time in clock cycles.
- Recovers the 8-bit position using the generator's encoding, high_cycles = (position + OFFSET) * 256, and reports loss-of-signal and malformed pulses.
- Output feeds the existing position/LED/7-segment path, so a servo channel can be looped back and checked on the board.

Parameters:
- OFFSET, 165: position offset in 256-cycle units; must match the generator.
- MIN_WIDTH, 42240: shortest legal high time in cycles, (0+165)*256.
- MAX_WIDTH, 107775: longest legal high time in cycles, (255+165)*256+255.
- TIMEOUT, 1500000: cycles without a rising edge before signal loss (30 ms at 50 MHz).
- CNT_W, 21: width of the width and period counters.

Ports:
- clk  input  1  system clock, 50 MHz.
- rst  input  1  reset; asynchronous, active-high.
- pwm_in  input  1  servo pulse input; asynchronous to clk.
- position  output  8  last decoded position, 0-255.
- pos_valid  output  1  one-cycle strobe when position is updated.
- pulse_err  output  1  one-cycle strobe when a pulse is rejected.
- signal_lost  output  1  high while no valid pulse train is present.

Behaviour:
- Reset: one clock; rst is asynchronous and active-high. While rst=1 or after its release:
  - outputs: position=0, pos_valid=0, pulse_err=0, signal_lost=1
  - synchronizer flops=0, counters=0, FSM=ARM
- Synchronizer and edges:
  - pwm_in passes through 2 flops (s1, s2); s3 holds the previous s2.
  - rise = s2 & ~s3; fall = ~s2 & s3.
- Width measurement:
  - On rise, width counter loads 1.
  - In HIGH, it increments on each cycle with s2=1.
  - Measured width equals pin high time in clk cycles, ±1 for asynchronous sampling.
- FSM states:
  - ARM: wait for s2=0, then go to WAIT_RISE. This discards a partial pulse after reset or error.
  - WAIT_RISE: on rise, go to HIGH.
  - HIGH, on fall:
    - evaluate width w.
    - If MIN_WIDTH <= w <= MAX_WIDTH: position <= w[CNT_W-1:8] - OFFSET (8-bit result, 0..255 by construction), pos_valid pulses for 1 cycle, signal_lost <= 0.
    - Otherwise: pulse_err pulses for 1 cycle and position holds.
    - Either way, go to WAIT_RISE.
  - HIGH, overrun: if the counter reaches MAX_WIDTH+1 while s2=1, pulse_err pulses for 1 cycle and the FSM goes to ARM. The counter saturates; it never wraps.
- Latency: pos_valid/position update is registered on the 3rd clk edge after the first edge that samples pwm_in low (2 sync stages + 1 output register).
- Period watchdog:
  - Counter clears on every rise and otherwise increments, saturating at TIMEOUT.
  - On reaching TIMEOUT, signal_lost <= 1 and position holds its last value.
  - signal_lost clears only on the next accepted pulse (pos_valid).
- Simultaneous events: a watchdog expiry in the same cycle as an accepted fall gives signal_lost=0, because the valid pulse wins.
- Strobes: pos_valid and pulse_err are never high in the same cycle.
- Mid-operation reset: asynchronous return to reset values. The first pulse after release is accepted only if its rise is seen after s2 has been 0 (ARM rule).

Test Plan:
- Loopback with generator position=128: high time (128+165)*256 = 75008 cycles, period 1,000,000 → pos_valid each period, position=128, signal_lost falls after the first pulse.
- Directed widths 42240, 42239, 107775 and 107776 cycles:
  - 42240 → position=0, pos_valid.
  - 42239 → pulse_err, position unchanged.
  - 107775 → position=255.
  - 107776 → pulse_err via overrun, then ARM.
- rst released while pwm_in=1 mid-pulse → no pos_valid or pulse_err for that pulse; the next full pulse of 75008 cycles gives position=128.
- pwm_in held low for 1,500,000 cycles after valid pulses → signal_lost=1 exactly at TIMEOUT, position holds. A later 60000-cycle pulse gives position=69 and signal_lost=0.
- Glitch: a 10-cycle high pulse → pulse_err 1 cycle, no pos_valid. Sweep positions 0..255 from the generator → decoded position matches every value with no pulse_err.
- Assert rst asynchronously mid-HIGH → outputs go immediately to reset values with no clk edge required.
